// File: rtl/mips_mmio_port.sv
// Memory-mapped I/O responder on the core data bus: output port register,
// synchronized input port with change flag, and a down-counting timer with irq.
module mips_mmio_port #(
    parameter logic [31:0] BASE_ADDR = 32'h1001_0000,
    parameter int          IN_WIDTH  = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [31:0]         address,
    input  logic [31:0]         write_data,
    input  logic                mem_write,
    input  logic                mem_read,
    output logic [31:0]         read_data,
    output logic                hit,
    input  logic [IN_WIDTH-1:0] port_in,
    output logic [31:0]         port_out,
    output logic                irq
);
    localparam logic [2:0] OFF_PORT_OUT = 3'd0;
    localparam logic [2:0] OFF_PORT_IN  = 3'd1;
    localparam logic [2:0] OFF_STATUS   = 3'd2;
    localparam logic [2:0] OFF_CTRL     = 3'd3;
    localparam logic [2:0] OFF_LOAD     = 3'd4;
    localparam logic [2:0] OFF_COUNT    = 3'd5;

    logic [IN_WIDTH-1:0] s1, in_sync, in_prev;
    logic [31:0]         load_q, count_q;
    logic [3:0]          ctrl_q;   // {EXP_IE, CHG_IE, ARL, TEN}
    logic                chg_q, exp_q;
    logic [2:0]          offset;
    logic                wr_en, chg_set, exp_set;
    logic                unused_ok;

    assign hit       = (address[31:5] == BASE_ADDR[31:5]);
    assign offset    = address[4:2];
    // Loads have no side effects and byte lanes are ignored.
    assign unused_ok = ^{address[1:0], mem_read};
    assign wr_en     = mem_write & hit;
    assign chg_set   = (in_sync != in_prev);
    assign exp_set   = ctrl_q[0] & (count_q == 32'd0);
    assign irq       = (chg_q & ctrl_q[2]) | (exp_q & ctrl_q[3]);

    always_comb begin
        read_data = 32'd0;
        if (hit) begin
            case (offset)
                OFF_PORT_OUT: read_data = port_out;
                OFF_PORT_IN:  read_data = 32'(in_sync);
                OFF_STATUS:   read_data = {30'd0, exp_q, chg_q};
                OFF_CTRL:     read_data = {28'd0, ctrl_q};
                OFF_LOAD:     read_data = load_q;
                OFF_COUNT:    read_data = count_q;
                default:      read_data = 32'd0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1       <= '0;
            in_sync  <= '0;
            in_prev  <= '0;
            port_out <= 32'd0;
            ctrl_q   <= 4'd0;
            load_q   <= 32'd0;
            count_q  <= 32'd0;
            chg_q    <= 1'b0;
            exp_q    <= 1'b0;
        end else begin
            s1      <= port_in;
            in_sync <= s1;
            in_prev <= in_sync;

            if (wr_en && offset == OFF_PORT_OUT)
                port_out <= write_data;

            // Hardware set dominates a simultaneous write-1-to-clear.
            chg_q <= chg_set | (chg_q & ~(wr_en && offset == OFF_STATUS && write_data[0]));
            exp_q <= exp_set | (exp_q & ~(wr_en && offset == OFF_STATUS && write_data[1]));

            if (wr_en && offset == OFF_CTRL)
                ctrl_q <= write_data[3:0];
            else if (exp_set && !ctrl_q[1])
                ctrl_q[0] <= 1'b0;

            if (wr_en && offset == OFF_LOAD)
                load_q <= write_data;

            // A software LOAD write overrides any decrement or reload.
            if (wr_en && offset == OFF_LOAD)
                count_q <= write_data;
            else if (ctrl_q[0]) begin
                if (count_q != 32'd0)
                    count_q <= count_q - 32'd1;
                else if (ctrl_q[1])
                    count_q <= load_q;
            end
        end
    end
endmodule

// File: tb/tb_mips_mmio_port.sv
// Bench for mips_mmio_port: register-map vector table plus timer, input-sync
// and collision sequences, checked through an expected-value queue.
module tb_mips_mmio_port;
    localparam logic [31:0] BASE = 32'h1001_0000;
    localparam logic [31:0] R_PO = BASE + 32'h00, R_PI = BASE + 32'h04, R_ST = BASE + 32'h08,
                            R_CT = BASE + 32'h0C, R_LD = BASE + 32'h10, R_CN = BASE + 32'h14;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] address = 32'd0, write_data = 32'd0;
    logic        mem_write = 1'b0, mem_read = 1'b0;
    logic [31:0] read_data, port_out;
    logic        hit, irq;
    logic [7:0]  port_in = 8'd0;

    int checks = 0;
    int failures = 0;
    logic [31:0] exp_q[$];

    mips_mmio_port #(.BASE_ADDR(BASE), .IN_WIDTH(8)) dut (
        .clk(clk), .reset(reset), .address(address), .write_data(write_data),
        .mem_write(mem_write), .mem_read(mem_read), .read_data(read_data),
        .hit(hit), .port_in(port_in), .port_out(port_out), .irq(irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        w;
        logic [31:0] a, d, ra, exp_rd, exp_po;
        logic        exp_hit, exp_irq;
    } tv_t;
    tv_t tv[10];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        address = a; write_data = d; mem_write = 1'b1; mem_read = 1'b0;
        tick();
        mem_write = 1'b0;
    endtask

    task automatic chk_sig(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Expected value queued at drive time, popped once the combinational read settles.
    task automatic chk_rd(input string name, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] e;
        address = a; mem_read = 1'b1; mem_write = 1'b0;
        exp_q.push_back(exp);
        #1;
        e = exp_q.pop_front();
        chk_sig(name, read_data, e);
        mem_read = 1'b0;
    endtask

    initial begin
        tv[0] = '{w:1, a:R_PO, d:32'hDEAD_BEEF, ra:R_PO, exp_rd:32'hDEAD_BEEF, exp_po:32'hDEAD_BEEF, exp_hit:1, exp_irq:0};
        tv[1] = '{w:1, a:BASE+32'h40, d:32'h1234_5678, ra:R_PO, exp_rd:32'hDEAD_BEEF, exp_po:32'hDEAD_BEEF, exp_hit:1, exp_irq:0};
        tv[2] = '{w:1, a:BASE+32'h18, d:32'hFFFF_FFFF, ra:BASE+32'h18, exp_rd:32'h0, exp_po:32'hDEAD_BEEF, exp_hit:1, exp_irq:0};
        tv[3] = '{w:1, a:BASE+32'h1C, d:32'hFFFF_FFFF, ra:BASE+32'h1C, exp_rd:32'h0, exp_po:32'hDEAD_BEEF, exp_hit:1, exp_irq:0};
        tv[4] = '{w:1, a:R_CT, d:32'hFFFF_FFF2, ra:R_CT, exp_rd:32'h2, exp_po:32'hDEAD_BEEF, exp_hit:1, exp_irq:0};
        tv[5] = '{w:1, a:R_LD, d:32'h55, ra:R_CN, exp_rd:32'h55, exp_po:32'hDEAD_BEEF, exp_hit:1, exp_irq:0};
        tv[6] = '{w:0, a:R_LD, d:32'h0, ra:R_LD, exp_rd:32'h55, exp_po:32'hDEAD_BEEF, exp_hit:1, exp_irq:0};
        tv[7] = '{w:1, a:BASE+32'h3, d:32'hCAFE_0001, ra:R_PO, exp_rd:32'hCAFE_0001, exp_po:32'hCAFE_0001, exp_hit:1, exp_irq:0};
        tv[8] = '{w:0, a:R_PO, d:32'h0, ra:BASE+32'h40, exp_rd:32'h0, exp_po:32'hCAFE_0001, exp_hit:0, exp_irq:0};
        tv[9] = '{w:1, a:R_CT, d:32'h0, ra:R_CT, exp_rd:32'h0, exp_po:32'hCAFE_0001, exp_hit:1, exp_irq:0};

        // Reset state
        tick(); tick();
        reset = 1'b0;
        chk_rd("rst_po", R_PO, 32'h0);
        chk_rd("rst_st", R_ST, 32'h0);
        chk_rd("rst_ct", R_CT, 32'h0);
        chk_rd("rst_cn", R_CN, 32'h0);
        chk_sig("rst_port_out", port_out, 32'h0);
        chk_sig("rst_irq", {31'd0, irq}, 32'h0);

        // Register-map vectors
        for (int i = 0; i < 10; i++) begin
            if (tv[i].w) wr(tv[i].a, tv[i].d);
            else tick();
            chk_rd($sformatf("vec%0d_rd", i), tv[i].ra, tv[i].exp_rd);
            address = tv[i].ra;
            #1;
            chk_sig($sformatf("vec%0d_hit", i), {31'd0, hit}, {31'd0, tv[i].exp_hit});
            chk_sig($sformatf("vec%0d_po", i), port_out, tv[i].exp_po);
            chk_sig($sformatf("vec%0d_irq", i), {31'd0, irq}, {31'd0, tv[i].exp_irq});
        end

        // Read and write strobes together count as a write
        address = R_PO; write_data = 32'h0F0F_0F0F; mem_write = 1'b1; mem_read = 1'b1;
        tick();
        mem_write = 1'b0;
        chk_sig("rw_both_po", port_out, 32'h0F0F_0F0F);

        // Input synchronizer and change flag
        port_in = 8'hA5;
        tick(); chk_rd("sync_c1", R_PI, 32'h0);
        tick(); chk_rd("sync_c2", BASE + 32'h7, 32'h0000_00A5);
        chk_rd("chg_c2", R_ST, 32'h0);
        tick(); chk_rd("chg_c3", R_ST, 32'h1);
        wr(R_ST, 32'h1); chk_rd("chg_w1c", R_ST, 32'h0);
        wr(R_CT, 32'h4); chk_sig("chg_irq_idle", {31'd0, irq}, 32'h0);
        port_in = 8'h5A;
        tick(); tick(); tick();
        chk_sig("chg_irq_set", {31'd0, irq}, 32'h1);
        wr(R_ST, 32'h1);
        chk_sig("chg_irq_clr", {31'd0, irq}, 32'h0);

        // One-shot timer
        wr(R_LD, 32'd3);
        wr(R_CT, 32'h1);
        chk_rd("os_cn3", R_CN, 32'd3);
        tick(); chk_rd("os_cn2", R_CN, 32'd2);
        tick(); chk_rd("os_cn1", R_CN, 32'd1);
        tick(); chk_rd("os_cn0", R_CN, 32'd0);
        chk_rd("os_st_pre", R_ST, 32'h0);
        tick(); chk_rd("os_st_exp", R_ST, 32'h2);
        chk_rd("os_ct_clr", R_CT, 32'h0);
        chk_sig("os_irq_masked", {31'd0, irq}, 32'h0);
        tick(); chk_rd("os_cn_hold", R_CN, 32'd0);
        wr(R_CT, 32'h8); chk_sig("os_irq_en", {31'd0, irq}, 32'h1);
        wr(R_ST, 32'h2); chk_sig("os_irq_w1c", {31'd0, irq}, 32'h0);

        // Auto-reload, and W1C colliding with a new expiry
        wr(R_LD, 32'd2);
        wr(R_CT, 32'hB);
        chk_rd("ar_cn2", R_CN, 32'd2);
        tick(); chk_rd("ar_cn1", R_CN, 32'd1);
        tick(); chk_rd("ar_cn0", R_CN, 32'd0);
        tick(); chk_rd("ar_reload", R_CN, 32'd2);
        chk_rd("ar_st", R_ST, 32'h2);
        chk_sig("ar_irq", {31'd0, irq}, 32'h1);
        wr(R_ST, 32'h2);
        chk_rd("ar_w1c_st", R_ST, 32'h0);
        chk_rd("ar_w1c_cn", R_CN, 32'd1);
        tick(); chk_rd("ar_cn0b", R_CN, 32'd0);
        wr(R_ST, 32'h2);
        chk_rd("ar_setwins", R_ST, 32'h2);
        chk_rd("ar_reload2", R_CN, 32'd2);
        chk_sig("ar_irq2", {31'd0, irq}, 32'h1);

        // LOAD write in the reload cycle wins for COUNT
        tick(); tick();
        chk_rd("col_cn0", R_CN, 32'd0);
        wr(R_LD, 32'd10);
        chk_rd("col_cn", R_CN, 32'd10);
        chk_rd("col_ld", R_LD, 32'd10);

        // Reset mid-count drops a concurrent PORT_OUT store
        tick();
        reset = 1'b1;
        address = R_PO; write_data = 32'h1111_1111; mem_write = 1'b1;
        tick();
        reset = 1'b0; mem_write = 1'b0;
        chk_sig("mr_port_out", port_out, 32'h0);
        chk_rd("mr_cn", R_CN, 32'h0);
        chk_rd("mr_ld", R_LD, 32'h0);
        chk_rd("mr_ct", R_CT, 32'h0);
        chk_rd("mr_st", R_ST, 32'h0);
        chk_sig("mr_irq", {31'd0, irq}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
